// File: rtl/ir_pkg.sv
// Shared NEC IR definitions: protocol timing in microseconds, clocking constants
// and the frame state encoding used by both the transmit and receive paths.
package ir_pkg;

    localparam int unsigned NEC_TICK_DIV      = 50;
    localparam int unsigned NEC_LEAD_MARK_US  = 9000;
    localparam int unsigned NEC_LEAD_SPACE_US = 4500;
    localparam int unsigned NEC_BIT_MARK_US   = 560;
    localparam int unsigned NEC_ZERO_SPACE_US = 560;
    localparam int unsigned NEC_ONE_SPACE_US  = 1690;
    localparam int unsigned NEC_CARRIER_HALF  = 658;

    localparam int unsigned US_W  = 14;
    localparam int unsigned PRE_W = 11;
    localparam int unsigned CAR_W = 11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEAD_MARK,
        ST_LEAD_SPACE,
        ST_BIT_MARK,
        ST_BIT_SPACE,
        ST_STOP_MARK,
        ST_DONE
    } ir_state_e;

endpackage

// File: rtl/ir_us_tick.sv
// Microsecond prescaler: counts 0..TICK_DIV-1 and strobes for one cycle at the
// top of the count; a synchronous clear realigns it to a state boundary.
module ir_us_tick
    import ir_pkg::*;
#(
    parameter int unsigned TICK_DIV = NEC_TICK_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam logic [PRE_W-1:0] LAST = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ir_tx.sv
// NEC infrared transmitter: serialises a 32-bit word MSB-first as leader,
// pulse-distance bits and a stop mark, with envelope and 38 kHz LED outputs.
module ir_tx
    import ir_pkg::*;
#(
    parameter int unsigned TICK_DIV      = NEC_TICK_DIV,
    parameter int unsigned LEAD_MARK_US  = NEC_LEAD_MARK_US,
    parameter int unsigned LEAD_SPACE_US = NEC_LEAD_SPACE_US,
    parameter int unsigned BIT_MARK_US   = NEC_BIT_MARK_US,
    parameter int unsigned ZERO_SPACE_US = NEC_ZERO_SPACE_US,
    parameter int unsigned ONE_SPACE_US  = NEC_ONE_SPACE_US,
    parameter int unsigned CARRIER_HALF  = NEC_CARRIER_HALF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    input  logic [31:0] i_data,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_ir_txb,
    output logic        o_ir_led
);

    localparam logic [US_W-1:0]  LM_LAST  = US_W'(LEAD_MARK_US - 1);
    localparam logic [US_W-1:0]  LS_LAST  = US_W'(LEAD_SPACE_US - 1);
    localparam logic [US_W-1:0]  BM_LAST  = US_W'(BIT_MARK_US - 1);
    localparam logic [US_W-1:0]  ZS_LAST  = US_W'(ZERO_SPACE_US - 1);
    localparam logic [US_W-1:0]  OS_LAST  = US_W'(ONE_SPACE_US - 1);
    localparam logic [CAR_W-1:0] CAR_LAST = CAR_W'(CARRIER_HALF - 1);

    ir_state_e        state;
    logic [31:0]      shreg;
    logic [5:0]       bit_cnt;
    logic [US_W-1:0]  us_cnt;
    logic [CAR_W-1:0] car_cnt;
    logic [US_W-1:0]  phase_last;
    logic             tick;
    logic             phase_end;
    logic             clr;

    ir_us_tick #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .tick  (tick)
    );

    always_comb begin
        phase_last = '0;
        case (state)
            ST_LEAD_MARK:  phase_last = LM_LAST;
            ST_LEAD_SPACE: phase_last = LS_LAST;
            ST_BIT_MARK:   phase_last = BM_LAST;
            ST_BIT_SPACE:  phase_last = shreg[31] ? OS_LAST : ZS_LAST;
            ST_STOP_MARK:  phase_last = BM_LAST;
            default:       phase_last = '0;
        endcase
        phase_end = tick && (us_cnt == phase_last) &&
                    (state != ST_IDLE) && (state != ST_DONE);
        // Timebase is held cleared outside timed states and realigned on every
        // state change, so each phase spans exactly length_us * TICK_DIV cycles.
        clr = phase_end || (state == ST_IDLE) || (state == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
            o_ir_txb <= 1'b1;
            o_ir_led <= 1'b0;
            shreg    <= '0;
            bit_cnt  <= '0;
            us_cnt   <= '0;
            car_cnt  <= '0;
        end else begin
            o_done <= 1'b0;

            if (clr) begin
                us_cnt <= '0;
            end else if (tick) begin
                us_cnt <= us_cnt + 1'b1;
            end

            // Carrier runs continuously; mark entries below restart it high.
            if (car_cnt == CAR_LAST) begin
                car_cnt <= '0;
                if (!o_ir_txb) begin
                    o_ir_led <= ~o_ir_led;
                end
            end else begin
                car_cnt <= car_cnt + 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        shreg    <= i_data;
                        bit_cnt  <= '0;
                        o_busy   <= 1'b1;
                        o_ir_txb <= 1'b0;
                        o_ir_led <= 1'b1;
                        car_cnt  <= '0;
                        state    <= ST_LEAD_MARK;
                    end
                end
                ST_LEAD_MARK: begin
                    if (phase_end) begin
                        o_ir_txb <= 1'b1;
                        o_ir_led <= 1'b0;
                        state    <= ST_LEAD_SPACE;
                    end
                end
                ST_LEAD_SPACE: begin
                    if (phase_end) begin
                        o_ir_txb <= 1'b0;
                        o_ir_led <= 1'b1;
                        car_cnt  <= '0;
                        state    <= ST_BIT_MARK;
                    end
                end
                ST_BIT_MARK: begin
                    if (phase_end) begin
                        o_ir_txb <= 1'b1;
                        o_ir_led <= 1'b0;
                        state    <= ST_BIT_SPACE;
                    end
                end
                ST_BIT_SPACE: begin
                    if (phase_end) begin
                        shreg    <= {shreg[30:0], 1'b0};
                        bit_cnt  <= bit_cnt + 6'd1;
                        o_ir_txb <= 1'b0;
                        o_ir_led <= 1'b1;
                        car_cnt  <= '0;
                        state    <= (bit_cnt == 6'd31) ? ST_STOP_MARK : ST_BIT_MARK;
                    end
                end
                ST_STOP_MARK: begin
                    if (phase_end) begin
                        o_done   <= 1'b1;
                        o_busy   <= 1'b0;
                        o_ir_txb <= 1'b1;
                        o_ir_led <= 1'b0;
                        state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ir_tx.sv
// Directed bench for ir_tx with shortened NEC timing: measures envelope run
// lengths, decodes bits from space widths and checks carrier and handshake.
module tb_ir_tx;

    localparam int TD = 2;
    localparam int LM = 90;
    localparam int LS = 45;
    localparam int BM = 6;
    localparam int ZS = 6;
    localparam int OS = 17;
    localparam int CH = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic [31:0] i_data = '0;
    logic        o_busy;
    logic        o_done;
    logic        o_ir_txb;
    logic        o_ir_led;

    int          vectors = 0;
    int          miscompares = 0;
    int          t = 0;
    int          inject_at = -1;
    logic [31:0] inject_word = '0;
    logic        hold_start = 1'b0;
    int          led_err = 0;

    ir_tx #(
        .TICK_DIV      (TD),
        .LEAD_MARK_US  (LM),
        .LEAD_SPACE_US (LS),
        .BIT_MARK_US   (BM),
        .ZERO_SPACE_US (ZS),
        .ONE_SPACE_US  (OS),
        .CARRIER_HALF  (CH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_start  (i_start),
        .i_data   (i_data),
        .o_busy   (o_busy),
        .o_done   (o_done),
        .o_ir_txb (o_ir_txb),
        .o_ir_led (o_ir_led)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        t++;
        i_start = hold_start || (t == inject_at);
        if (t == inject_at) i_data = inject_word;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Length of the current envelope level, checking the LED against the
    // expected carrier phase (high for the first CH cycles of each mark).
    task automatic run(input logic lvl, output int n);
        n = 0;
        while (o_ir_txb === lvl && n < 5000) begin
            if (lvl == 1'b0) begin
                if (o_ir_led !== (((n / CH) % 2) == 0)) led_err++;
            end else if (o_ir_led !== 1'b0) begin
                led_err++;
            end
            step();
            n++;
        end
    endtask

    task automatic start_frame(input logic [31:0] word);
        i_data  = word;
        i_start = 1'b1;
        t = -1;
        step();
    endtask

    // Called just after the start edge (t == 0); ends one cycle after DONE.
    task automatic check_frame(input string tag, input logic [31:0] word, input int exp_total);
        int n;
        int mark_err;
        logic [31:0] dec;
        mark_err = 0;
        dec = '0;
        led_err = 0;
        chk({tag, "_busy_at_start"}, 32'(o_busy), 32'd1);
        run(1'b0, n);
        chk({tag, "_lead_mark"}, 32'(n), 32'(LM * TD));
        run(1'b1, n);
        chk({tag, "_lead_space"}, 32'(n), 32'(LS * TD));
        for (int i = 0; i < 32; i++) begin
            run(1'b0, n);
            if (n != BM * TD) mark_err++;
            run(1'b1, n);
            if (n != OS * TD && n != ZS * TD) mark_err++;
            dec = {dec[30:0], (n == OS * TD)};
        end
        chk({tag, "_bit_widths"}, 32'(mark_err), 32'd0);
        chk({tag, "_decoded_word"}, dec, word);
        run(1'b0, n);
        chk({tag, "_stop_mark"}, 32'(n), 32'(BM * TD));
        chk({tag, "_done_cycle"}, 32'(t), 32'(exp_total));
        chk({tag, "_done_high"}, 32'(o_done), 32'd1);
        chk({tag, "_busy_low"}, 32'(o_busy), 32'd0);
        chk({tag, "_led_carrier"}, 32'(led_err), 32'd0);
        step();
        chk({tag, "_done_pulse_end"}, 32'(o_done), 32'd0);
    endtask

    initial begin
        int err;
        int n;

        // Reset and idle
        step(); step(); step();
        chk("reset_txb", 32'(o_ir_txb), 32'd1);
        chk("reset_led", 32'(o_ir_led), 32'd0);
        chk("reset_busy", 32'(o_busy), 32'd0);
        chk("reset_done", 32'(o_done), 32'd0);
        rst_n = 1'b1;
        err = 0;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (o_ir_txb !== 1'b1 || o_ir_led !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0) err++;
        end
        chk("idle_1000", 32'(err), 32'd0);

        // Asynchronous reset in the middle of the leader mark
        start_frame(32'hA5A5_5A5A);
        for (int i = 0; i < 50; i++) step();
        chk("pre_reset_txb", 32'(o_ir_txb), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("async_rst_txb", 32'(o_ir_txb), 32'd1);
        chk("async_rst_led", 32'(o_ir_led), 32'd0);
        chk("async_rst_busy", 32'(o_busy), 32'd0);
        chk("async_rst_done", 32'(o_done), 32'd0);
        step(); step();
        rst_n = 1'b1;
        err = 0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (o_done !== 1'b0 || o_ir_txb !== 1'b1 || o_busy !== 1'b0) err++;
        end
        chk("post_reset_quiet", 32'(err), 32'd0);

        // Reference word, then all-zeros and all-ones frames
        start_frame(32'h00FF_A25D);
        check_frame("w00ffa25d", 32'h00FF_A25D, 1402);
        step(); step();
        start_frame(32'h0000_0000);
        check_frame("zeros", 32'h0000_0000, 1050);
        step(); step();
        start_frame(32'hFFFF_FFFF);
        check_frame("ones", 32'hFFFF_FFFF, 1754);
        step(); step();

        // Start pulse with a different word mid-frame must be ignored
        inject_word = 32'hFFFF_0000;
        inject_at = 400;
        start_frame(32'h1234_5678);
        check_frame("ignore_start", 32'h1234_5678, 1336);
        inject_at = -1;
        err = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (o_ir_txb !== 1'b1 || o_busy !== 1'b0) err++;
        end
        chk("ignored_word_not_sent", 32'(err), 32'd0);

        // Start held high: next leader begins after exactly one idle cycle
        hold_start = 1'b1;
        start_frame(32'h0000_0000);
        check_frame("b2b_first", 32'h0000_0000, 1050);
        chk("b2b_idle_txb", 32'(o_ir_txb), 32'd1);
        chk("b2b_idle_busy", 32'(o_busy), 32'd0);
        step();
        chk("b2b_restart_txb", 32'(o_ir_txb), 32'd0);
        chk("b2b_restart_busy", 32'(o_busy), 32'd1);
        hold_start = 1'b0;
        i_start = 1'b0;
        t = 0;
        check_frame("b2b_second", 32'h0000_0000, 1050);
        run(1'b1, n);
        chk("b2b_final_idle", 32'(n), 32'd5000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
